// File: rtl/monolith_pkg.sv
// monolith_pkg
// Shared definitions for the Monolith Bars layer over the Mersenne-31 field.
//   P_M31              field modulus 2^31 - 1
//   barInvState_e      FSM states of the sequential inverse Bars block
//   reduce_m31         maps the unreduced value p onto 0
//   sbox8 / sbox7      forward chunk S-boxes
//   sbox8_inv / _inv7  inverse S-boxes, read from constant tables
//   bar_fwd / bar_inv  whole-word forward and inverse Bar maps
package monolith_pkg;

  localparam int M31_WIDTH = 31;
  localparam logic [30:0] P_M31 = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } barInvState_e;

  // A word equal to p is the second encoding of zero.
  function automatic logic [30:0] reduce_m31(input logic [30:0] w);
    return (w == P_M31) ? 31'd0 : w;
  endfunction

  // S(x) = rotl1(x ^ (rotl1(~x) & rotl2(x) & rotl3(x))) on 8 bits.
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] nx;
    logic [7:0] t;
    nx = ~x;
    t  = x ^ ({nx[6:0], nx[7]} & {x[5:0], x[7:6]} & {x[4:0], x[7:5]});
    return {t[6:0], t[7]};
  endfunction

  // Same S-box on the 7-bit top chunk.
  function automatic logic [6:0] sbox7(input logic [6:0] x);
    logic [6:0] nx;
    logic [6:0] t;
    nx = ~x;
    t  = x ^ ({nx[5:0], nx[6]} & {x[4:0], x[6:5]} & {x[3:0], x[6:4]});
    return {t[5:0], t[6]};
  endfunction

  // The inverse tables are produced by scattering every z to slot S(z);
  // this runs at elaboration, so hardware only sees constant ROMs.
  function automatic logic [255:0][7:0] build_inv8();
    logic [255:0][7:0] t;
    t = '0;
    for (int z = 0; z < 256; z++) begin
      t[sbox8(8'(z))] = 8'(z);
    end
    return t;
  endfunction

  function automatic logic [127:0][6:0] build_inv7();
    logic [127:0][6:0] t;
    t = '0;
    for (int z = 0; z < 128; z++) begin
      t[sbox7(7'(z))] = 7'(z);
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] INV8_TABLE = build_inv8();
  localparam logic [127:0][6:0] INV7_TABLE = build_inv7();

  function automatic logic [7:0] sbox8_inv(input logic [7:0] y);
    return INV8_TABLE[y];
  endfunction

  function automatic logic [6:0] sbox7_inv(input logic [6:0] y);
    return INV7_TABLE[y];
  endfunction

  function automatic logic [30:0] bar_fwd(input logic [30:0] w);
    return {sbox7(w[30:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
  endfunction

  function automatic logic [30:0] bar_inv(input logic [30:0] w);
    return {sbox7_inv(w[30:24]), sbox8_inv(w[23:16]), sbox8_inv(w[15:8]),
            sbox8_inv(w[7:0])};
  endfunction

endpackage

// File: rtl/monolith_bar_inv_word.sv
// monolith_bar_inv_word
// Combinational inverse Bar map on one Mersenne-31 word: four inverse
// S-box lookups, three on the 8-bit chunks and one on the 7-bit top chunk.
//   i_word  in   31  reduced field word
//   o_word  out  31  word z with Bar(z) = i_word
module monolith_bar_inv_word
  import monolith_pkg::*;
(
  input  logic [M31_WIDTH-1:0] i_word,
  output logic [M31_WIDTH-1:0] o_word
);

  // Chunks are independent, so each one goes through its own table.
  assign o_word = {sbox7_inv(i_word[30:24]),
                   sbox8_inv(i_word[23:16]),
                   sbox8_inv(i_word[15:8]),
                   sbox8_inv(i_word[7:0])};

endmodule

// File: rtl/monolith_bars_inv.sv
// monolith_bars_inv
// Sequential inverse of the Monolith Bars layer. A captured state is
// reduced, then words 0..BAR_OP_COUNT-1 are inverted one per cycle through
// a single shared word inverter; the remaining words pass through reduced.
//   clk        in   1                      rising-edge clock
//   reset      in   1                      synchronous active-high reset
//   in_valid   in   1                      state_in is valid
//   in_ready   out  1                      block can accept a state
//   state_in   in   STATE_SIZE x WORD_WIDTH input state, p allowed for 0
//   out_valid  out  1                      state_out holds a result
//   out_ready  in   1                      consumer takes the result
//   state_out  out  STATE_SIZE x WORD_WIDTH inverted state, words below p
//   busy       out  1                      FSM is in RUN or DONE
module monolith_bars_inv
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH   = 31,
  parameter int STATE_SIZE   = 16,
  parameter int BAR_OP_COUNT = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out,
  output logic                                 busy
);

  localparam int IDX_W    = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam int LAST_IDX = (BAR_OP_COUNT > 0) ? BAR_OP_COUNT - 1 : 0;

  // Unsupported parameterisations stop elaboration outright.
  if (WORD_WIDTH != 31) begin : gBadWidth
    $error("monolith_bars_inv: WORD_WIDTH must be 31");
  end
  if (BAR_OP_COUNT < 0 || BAR_OP_COUNT > STATE_SIZE) begin : gBadCount
    $error("monolith_bars_inv: BAR_OP_COUNT must lie in 0..STATE_SIZE");
  end

  barInvState_e                          r_fsm;
  barInvState_e                          w_fsmNext;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] r_state;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] w_stateNext;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] r_stateOut;
  logic [IDX_W-1:0]                      r_idx;
  logic [IDX_W-1:0]                      w_idxNext;
  logic                                  w_loadOut;
  logic [WORD_WIDTH-1:0]                 w_curWord;
  logic [WORD_WIDTH-1:0]                 w_invWord;

  // The single inverter always looks at the word the index points to.
  assign w_curWord = r_state[r_idx];

  monolith_bar_inv_word u_wordInv (
    .i_word (w_curWord),
    .o_word (w_invWord)
  );

  // Next-state logic: capture with reduction in IDLE, one word per cycle in
  // RUN, hold in DONE until the consumer takes the result.
  always_comb begin
    w_fsmNext   = r_fsm;
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < STATE_SIZE; i++) begin
            w_stateNext[i] = reduce_m31(state_in[i]);
          end
          w_idxNext = '0;
          w_fsmNext = (BAR_OP_COUNT == 0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_stateNext[r_idx] = w_invWord;
        w_idxNext          = r_idx + 1'b1;
        if (r_idx == IDX_W'(LAST_IDX)) begin
          w_fsmNext = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_fsmNext = IDLE;
        end
      end
      default: begin
        w_fsmNext = IDLE;
      end
    endcase
  end

  // The output register is loaded only on entry to DONE, so it keeps the
  // last result steady while a new state is being worked on.
  assign w_loadOut = (w_fsmNext == DONE) && (r_fsm != DONE);

  // State register, working copy, index and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_state    <= '0;
      r_idx      <= '0;
      r_stateOut <= '0;
    end else begin
      r_fsm   <= w_fsmNext;
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      if (w_loadOut) begin
        r_stateOut <= w_stateNext;
      end
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm != IDLE);
  assign state_out = r_stateOut;

  // All-ones chunks are S-box fixed points, so a reduced input can never
  // invert to p; this guards that property on every presented word.
  for (genvar g = 0; g < STATE_SIZE; g++) begin : gRangeCheck
    assert property (@(posedge clk) disable iff (reset)
                     out_valid |-> (state_out[g] < WORD_WIDTH'(P_M31)));
  end

endmodule

// File: tb/tb_monolith_bars_inv.sv
// tb_monolith_bars_inv
// Scoreboard bench for monolith_bars_inv: expected states are queued when a
// state is driven and compared when the block presents its result. Two
// extra instances cover the BAR_OP_COUNT = 0 and = STATE_SIZE builds.
module tb_monolith_bars_inv;
  import monolith_pkg::*;

  localparam int SS  = 16;
  localparam int BOC = 8;

  typedef logic [SS-1:0][30:0] stateVec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid, inReady, outValid, outReady, busy;
  stateVec_t  stateIn, stateOut;
  logic       zInValid, zInReady, zOutValid, zOutReady, zBusy;
  stateVec_t  zStateIn, zStateOut;
  logic       fInValid, fInReady, fOutValid, fOutReady, fBusy;
  stateVec_t  fStateIn, fStateOut;

  int         totalChecks = 0;
  int         badChecks   = 0;
  stateVec_t  expQ[$];

  always #5 clk = ~clk;

  monolith_bars_inv #(.WORD_WIDTH(31), .STATE_SIZE(SS), .BAR_OP_COUNT(BOC)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .state_in(stateIn), .out_valid(outValid), .out_ready(outReady),
    .state_out(stateOut), .busy(busy));

  monolith_bars_inv #(.WORD_WIDTH(31), .STATE_SIZE(SS), .BAR_OP_COUNT(0)) dutZero (
    .clk(clk), .reset(reset), .in_valid(zInValid), .in_ready(zInReady),
    .state_in(zStateIn), .out_valid(zOutValid), .out_ready(zOutReady),
    .state_out(zStateOut), .busy(zBusy));

  monolith_bars_inv #(.WORD_WIDTH(31), .STATE_SIZE(SS), .BAR_OP_COUNT(SS)) dutFull (
    .clk(clk), .reset(reset), .in_valid(fInValid), .in_ready(fInReady),
    .state_in(fStateIn), .out_valid(fOutValid), .out_ready(fOutReady),
    .state_out(fStateOut), .busy(fBusy));

  // Keeps a broken design from hanging the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random field element, zero about one time in eight.
  function automatic logic [30:0] rand_field();
    if ($urandom_range(0, 7) == 0) return 31'd0;
    return 31'($urandom_range(1, 32'h7FFF_FFFE));
  endfunction

  // Builds a stimulus from a random original: the first nInv words go
  // through the forward Bar map, zero words are sometimes written as p.
  function automatic void make_pair(input int nInv, output stateVec_t stim,
                                    output stateVec_t expd);
    logic [30:0] orig;
    logic [30:0] word;
    for (int i = 0; i < SS; i++) begin
      orig    = rand_field();
      expd[i] = orig;
      word    = (i < nInv) ? bar_fwd(orig) : orig;
      if (word == 31'd0 && $urandom_range(0, 1) == 1) word = P_M31;
      stim[i] = word;
    end
  endfunction

  // Holds in_valid until accepted; returns just after the capture edge.
  task automatic capture_state(input stateVec_t s, output bit ok);
    int waited = 0;
    inValid = 1'b1;
    stateIn = s;
    while (!inReady && waited < 40) begin
      tick();
      waited++;
    end
    ok = inReady;
    if (ok) tick();
    inValid = 1'b0;
  endtask

  // Counts edges until out_valid shows up and returns what was presented.
  task automatic collect_output(input int maxCycles, output stateVec_t got,
                                output int cycles, output bit seen);
    cycles = 0;
    while (!outValid && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    seen = outValid;
    got  = stateOut;
  endtask

  task automatic release_output();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inValid = 1'b0; outReady = 1'b0; stateIn = '0;
    zInValid = 1'b0; zOutReady = 1'b0; zStateIn = '0;
    fInValid = 1'b0; fOutReady = 1'b0; fStateIn = '0;
    repeat (2) tick();
    reset = 1'b0;
    totalChecks++;
    if (inReady !== 1'b1) begin
      badChecks++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady);
    end
    totalChecks++;
    if (outValid !== 1'b0) begin
      badChecks++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid);
    end
    totalChecks++;
    if (busy !== 1'b0) begin
      badChecks++; $display("[TB] FAIL reset_busy got=%b exp=0", busy);
    end
    totalChecks++;
    if (stateOut !== '0) begin
      badChecks++; $display("[TB] FAIL reset_state_out got=%h exp=0", stateOut);
    end
    totalChecks++;
    if (zOutValid !== 1'b0 || fOutValid !== 1'b0 || zBusy !== 1'b0 || fBusy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_other_builds got=%b%b%b%b exp=0000",
               zOutValid, fOutValid, zBusy, fBusy);
    end
  endtask

  task automatic test_known_vectors();
    stateVec_t stim[3];
    stateVec_t expd[3];
    stateVec_t got, e;
    int        cycles;
    bit        ok, seen;
    stim[0] = '0; stim[0][0] = 31'h0202_0202;
    expd[0] = '0; expd[0][0] = 31'h0101_0101;
    // Each 8-bit chunk 0x01 inverts to 0x80, the 7-bit chunk 0x01 to 0x40.
    stim[1] = '0; stim[1][0] = 31'h0101_0101;
    expd[1] = '0; expd[1][0] = 31'h4080_8080;
    // p on an inverted and a pass-through word; word 10 must pass unchanged.
    stim[2] = '0; stim[2][3] = P_M31; stim[2][9] = P_M31; stim[2][10] = 31'h1234_5678;
    expd[2] = '0; expd[2][10] = 31'h1234_5678;
    for (int v = 0; v < 3; v++) begin
      expQ.push_back(expd[v]);
      capture_state(stim[v], ok);
      totalChecks++;
      if (!ok || busy !== 1'b1 || inReady !== 1'b0) begin
        badChecks++;
        $display("[TB] FAIL vec%0d_accept got=ok%b busy%b rdy%b exp=ok1 busy1 rdy0",
                 v, ok, busy, inReady);
      end
      collect_output(30, got, cycles, seen);
      e = expQ.pop_front();
      totalChecks++;
      if (!seen || cycles != BOC) begin
        badChecks++;
        $display("[TB] FAIL vec%0d_latency got=%0d seen=%b exp=%0d", v, cycles, seen, BOC);
      end
      totalChecks++;
      if (got !== e) begin
        badChecks++; $display("[TB] FAIL vec%0d_state got=%h exp=%h", v, got, e);
      end
      if (v == 1) begin
        totalChecks++;
        if (got[0] !== bar_inv(31'h0101_0101)) begin
          badChecks++;
          $display("[TB] FAIL vec1_pkg_model got=%h exp=%h", got[0], bar_inv(31'h0101_0101));
        end
      end
      release_output();
    end
  endtask

  task automatic test_backpressure();
    stateVec_t s1, e1, s2, e2, got, e;
    int        cycles;
    bit        ok, seen;
    make_pair(BOC, s1, e1);
    make_pair(BOC, s2, e2);
    expQ.push_back(e1);
    capture_state(s1, ok);
    collect_output(30, got, cycles, seen);
    e = expQ.pop_front();
    totalChecks++;
    if (!ok || !seen || got !== e) begin
      badChecks++; $display("[TB] FAIL bp_first got=%h exp=%h", got, e);
    end
    // A second state is offered while the result is stalled; it must wait.
    inValid = 1'b1;
    stateIn = s2;
    for (int c = 0; c < 20; c++) begin
      tick();
      totalChecks++;
      if (outValid !== 1'b1 || inReady !== 1'b0 || stateOut !== e) begin
        badChecks++;
        $display("[TB] FAIL bp_hold cyc%0d got=v%b r%b %h exp=v1 r0 %h",
                 c, outValid, inReady, stateOut, e);
      end
    end
    expQ.push_back(e2);
    release_output();
    capture_state(s2, ok);
    collect_output(30, got, cycles, seen);
    e = expQ.pop_front();
    totalChecks++;
    if (!ok || !seen || cycles != BOC || got !== e) begin
      badChecks++;
      $display("[TB] FAIL bp_second got=%h lat=%0d exp=%h lat=%0d", got, cycles, e, BOC);
    end
    release_output();
  endtask

  task automatic test_reset_mid_run();
    stateVec_t s, e, got, ex;
    int        cycles;
    bit        ok, seen, sawValid;
    make_pair(BOC, s, e);
    capture_state(s, ok);
    repeat (4) tick();
    totalChecks++;
    if (!ok || busy !== 1'b1 || outValid !== 1'b0) begin
      badChecks++; $display("[TB] FAIL midrun_running got=busy%b exp=busy1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    totalChecks++;
    if (inReady !== 1'b1 || busy !== 1'b0 || outValid !== 1'b0 || stateOut !== '0) begin
      badChecks++;
      $display("[TB] FAIL midrun_idle got=r%b b%b v%b %h exp=r1 b0 v0 0",
               inReady, busy, outValid, stateOut);
    end
    sawValid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (outValid) sawValid = 1'b1;
    end
    totalChecks++;
    if (sawValid) begin
      badChecks++; $display("[TB] FAIL midrun_no_output got=1 exp=0");
    end
    make_pair(BOC, s, e);
    expQ.push_back(e);
    capture_state(s, ok);
    collect_output(30, got, cycles, seen);
    ex = expQ.pop_front();
    totalChecks++;
    if (!ok || !seen || got !== ex) begin
      badChecks++; $display("[TB] FAIL midrun_recover got=%h exp=%h", got, ex);
    end
    release_output();
  endtask

  task automatic test_back_to_back();
    stateVec_t stim[5];
    stateVec_t expd[5];
    stateVec_t e;
    int        capCyc[5];
    int        sent = 0, recv = 0, cyc = 0;
    bit        readyBefore;
    for (int i = 0; i < 5; i++) make_pair(BOC, stim[i], expd[i]);
    outReady    = 1'b1;
    inValid     = 1'b1;
    stateIn     = stim[0];
    readyBefore = inReady;
    while (recv < 5 && cyc < 200) begin
      tick();
      cyc++;
      if (readyBefore && inValid) begin
        expQ.push_back(expd[sent]);
        capCyc[sent] = cyc;
        sent++;
        if (sent < 5) stateIn = stim[sent];
        else inValid = 1'b0;
      end
      if (outValid) begin
        totalChecks++;
        if (expQ.size() == 0) begin
          badChecks++; $display("[TB] FAIL b2b_unexpected got=%h exp=none", stateOut);
        end else begin
          e = expQ.pop_front();
          if (stateOut !== e) begin
            badChecks++; $display("[TB] FAIL b2b_state%0d got=%h exp=%h", recv, stateOut, e);
          end
        end
        recv++;
      end
      readyBefore = inReady;
    end
    tick();
    outReady = 1'b0;
    inValid  = 1'b0;
    totalChecks++;
    if (recv != 5) begin
      badChecks++; $display("[TB] FAIL b2b_count got=%0d exp=5", recv);
    end
    for (int i = 1; i < sent; i++) begin
      totalChecks++;
      if (capCyc[i] - capCyc[i-1] != BOC + 2) begin
        badChecks++;
        $display("[TB] FAIL b2b_period%0d got=%0d exp=%0d", i, capCyc[i] - capCyc[i-1], BOC + 2);
      end
    end
  endtask

  task automatic test_random_roundtrip();
    stateVec_t s, e, got, ex;
    int        cycles;
    bit        ok, seen;
    for (int n = 0; n < 200; n++) begin
      make_pair(BOC, s, e);
      expQ.push_back(e);
      capture_state(s, ok);
      collect_output(30, got, cycles, seen);
      ex = expQ.pop_front();
      totalChecks++;
      if (!ok || !seen || got !== ex) begin
        badChecks++; $display("[TB] FAIL roundtrip%0d got=%h exp=%h", n, got, ex);
      end
      release_output();
    end
  endtask

  task automatic test_param_builds();
    stateVec_t s, e, ex;
    int        cycles;
    // With no words to invert the result is ready right after capture.
    make_pair(0, s, e);
    expQ.push_back(e);
    zInValid = 1'b1;
    zStateIn = s;
    totalChecks++;
    if (zInReady !== 1'b1) begin
      badChecks++; $display("[TB] FAIL zero_ready got=%b exp=1", zInReady);
    end
    tick();
    zInValid = 1'b0;
    ex = expQ.pop_front();
    totalChecks++;
    if (zOutValid !== 1'b1 || zBusy !== 1'b1 || zStateOut !== ex) begin
      badChecks++;
      $display("[TB] FAIL zero_passthru got=v%b b%b %h exp=v1 b1 %h",
               zOutValid, zBusy, zStateOut, ex);
    end
    zOutReady = 1'b1;
    tick();
    zOutReady = 1'b0;
    totalChecks++;
    if (zOutValid !== 1'b0 || zInReady !== 1'b1) begin
      badChecks++; $display("[TB] FAIL zero_release got=v%b r%b exp=v0 r1", zOutValid, zInReady);
    end
    // Full-width build inverts every word, one per cycle.
    make_pair(SS, s, e);
    expQ.push_back(e);
    fInValid = 1'b1;
    fStateIn = s;
    tick();
    fInValid = 1'b0;
    cycles = 0;
    while (!fOutValid && cycles < 40) begin
      tick();
      cycles++;
    end
    ex = expQ.pop_front();
    totalChecks++;
    if (!fOutValid || cycles != SS) begin
      badChecks++; $display("[TB] FAIL full_latency got=%0d exp=%0d", cycles, SS);
    end
    totalChecks++;
    if (fStateOut !== ex || fBusy !== 1'b1 || fInReady !== 1'b0) begin
      badChecks++; $display("[TB] FAIL full_state got=%h exp=%h", fStateOut, ex);
    end
    fOutReady = 1'b1;
    tick();
    fOutReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random_roundtrip();
    test_param_builds();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
